// File: rtl/distance_scan_ctrl_if.sv
// distance_scan_ctrl_if
//   Bundles the coordinate-memory read port and the distance-unit streaming
//   port used by distance_scan_ctrl.
//   master : the scan controller (drives reads and per-dimension valids)
//   slave  : memory + distance unit side
//   Signals:
//     mem_rd_out           read strobe
//     mem_addr_out         coordinate word address
//     mem_data_in          coordinate word, MEM_LAT cycles after the strobe
//     dist_valid_out       one-hot per-dimension valid
//     dist_vertex_pos_out  per-dimension coordinate
//     dist_result_in       squared distance from the distance unit
//     dist_result_valid_in result strobe
interface distance_scan_ctrl_if #(
  parameter int DIM     = 9,
  parameter int CADDR_W = 20
);
  logic                    mem_rd_out;
  logic [CADDR_W-1:0]      mem_addr_out;
  logic [31:0]             mem_data_in;
  logic [DIM-1:0]          dist_valid_out;
  logic [DIM-1:0][31:0]    dist_vertex_pos_out;
  logic [31:0]             dist_result_in;
  logic                    dist_result_valid_in;

  modport master (
    output mem_rd_out, mem_addr_out, dist_valid_out, dist_vertex_pos_out,
    input  mem_data_in, dist_result_in, dist_result_valid_in
  );

  modport slave (
    input  mem_rd_out, mem_addr_out, dist_valid_out, dist_vertex_pos_out,
    output mem_data_in, dist_result_in, dist_result_valid_in
  );
endinterface

// File: rtl/distance_scan_ctrl.sv
// distance_scan_ctrl
//   Streams the coordinates of vertices [base, base+count) out of coordinate
//   memory into the shared distance unit, one dimension per cycle, and keeps
//   the nearest vertex seen.
//   Optional feature macro: SCAN_TIMEOUT_EN (drain watchdog + timeout_out).
//   Ports:
//     clk_in, rst_in          clock, synchronous active-high reset
//     start_in                command pulse, accepted only when idle
//     base_idx_in, count_in   first vertex index and vertex count
//     busy_out                scan in progress (through the done cycle)
//     best_dist_out           smallest squared distance seen
//     best_idx_out            vertex index of best_dist_out
//     found_out               at least one result compared
//     done_out                one-cycle completion pulse
//     timeout_out             (SCAN_TIMEOUT_EN only) done caused by watchdog
//     bus                     memory + distance-unit port bundle (master)
//
//   state  | meaning
//   IDLE   | waiting for start_in; results ignored
//   ISSUE  | one coordinate read per cycle, count*DIM reads in total
//   DRAIN  | reads finished, waiting for outstanding distance results
//   DONE   | one-cycle done pulse, then back to IDLE
module distance_scan_ctrl #(
  parameter int DIM            = 9,
  parameter int IDX_W          = 16,
  parameter int CADDR_W        = 20,
  parameter int MEM_LAT        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [IDX_W-1:0]     base_idx_in,
  input  logic [IDX_W-1:0]     count_in,
  output logic                 busy_out,
  output logic [31:0]          best_dist_out,
  output logic [IDX_W-1:0]     best_idx_out,
  output logic                 found_out,
  output logic                 done_out,
`ifdef SCAN_TIMEOUT_EN
  output logic                 timeout_out,
`endif
  distance_scan_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW = (DIM > 1) ? $clog2(DIM) : 1;

  logic [1:0]                 state_q, state_d;
  logic [IDX_W-1:0]           base_q, base_d;
  logic [IDX_W-1:0]           count_q, count_d;
  logic [IDX_W-1:0]           vtx_q, vtx_d;
  logic [DW-1:0]              dim_q, dim_d;
  logic [IDX_W-1:0]           res_cnt_q, res_cnt_d;
  logic                       found_q, found_d;
  logic [31:0]                best_dist_q, best_dist_d;
  logic [IDX_W-1:0]           best_idx_q, best_idx_d;
  logic [MEM_LAT-1:0]         pipe_v_q, pipe_v_d;
  logic [MEM_LAT-1:0][DW-1:0] pipe_d_q, pipe_d_d;
  logic [DIM-1:0][31:0]       pos_q, pos_d;

  logic                       issue;
  logic                       res_take;
  logic                       exit_v;
  logic [DW-1:0]              exit_d;
  logic [DIM-1:0]             lane_hit;

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       timeout_q, timeout_d;
`endif

  assign issue    = (state_q == S_ISSUE);
  assign res_take = bus.dist_result_valid_in &&
                    ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign exit_v   = pipe_v_q[MEM_LAT-1];
  assign exit_d   = pipe_d_q[MEM_LAT-1];

  assign busy_out          = (state_q != S_IDLE);
  assign done_out          = (state_q == S_DONE);
  assign best_dist_out     = best_dist_q;
  assign best_idx_out      = best_idx_q;
  assign found_out         = found_q;
  assign bus.mem_rd_out    = issue;
  // Modular CADDR_W arithmetic gives the truncated (base+vtx)*DIM+d directly.
  assign bus.mem_addr_out  = issue ?
    ((CADDR_W'(base_q) + CADDR_W'(vtx_q)) * CADDR_W'(DIM) + CADDR_W'(dim_q)) :
    '0;
`ifdef SCAN_TIMEOUT_EN
  assign timeout_out       = timeout_q;
`endif

  // Read data is only valid in the exit cycle, so the selected lane passes
  // mem_data_in straight through and the register holds it afterwards.
  always_comb begin
    lane_hit = '0;
    pos_d    = pos_q;
    for (int d = 0; d < DIM; d++) begin
      lane_hit[d] = exit_v && (exit_d == DW'(d));
      if (lane_hit[d]) begin
        pos_d[d] = bus.mem_data_in;
      end
    end
  end

  assign bus.dist_valid_out      = lane_hit;
  assign bus.dist_vertex_pos_out = pos_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    vtx_d       = vtx_q;
    dim_d       = dim_q;
    res_cnt_d   = res_cnt_q;
    found_d     = found_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
`ifdef SCAN_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = 1'b0;
`endif

    pipe_v_d[0] = issue;
    pipe_d_d[0] = dim_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_d_d[i] = pipe_d_q[i-1];
    end

    // Results return in issue order: result k belongs to vertex base+k.
    if (res_take) begin
      res_cnt_d = res_cnt_q + IDX_W'(1);
      found_d   = 1'b1;
      if (bus.dist_result_in < best_dist_q) begin
        best_dist_d = bus.dist_result_in;
        best_idx_d  = base_q + res_cnt_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          base_d      = base_idx_in;
          count_d     = count_in;
          vtx_d       = '0;
          dim_d       = '0;
          res_cnt_d   = '0;
          found_d     = 1'b0;
          best_dist_d = '1;
          best_idx_d  = '0;
          state_d     = (count_in != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (dim_q == DW'(DIM - 1)) begin
          dim_d = '0;
          vtx_d = vtx_q + IDX_W'(1);
          if (vtx_q == count_q - IDX_W'(1)) begin
            state_d = S_DRAIN;
`ifdef SCAN_TIMEOUT_EN
            tmo_d   = TW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end else begin
          dim_d = dim_q + DW'(1);
        end
      end
      S_DRAIN: begin
        // Using the next count lets done follow the final result by one cycle.
        if (res_cnt_d == count_q) begin
          state_d = S_DONE;
`ifdef SCAN_TIMEOUT_EN
        end else if (res_take) begin
          tmo_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (tmo_q == '0) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      vtx_q       <= '0;
      dim_q       <= '0;
      res_cnt_q   <= '0;
      found_q     <= 1'b0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
      pipe_v_q    <= '0;
      pipe_d_q    <= '0;
      pos_q       <= '0;
`ifdef SCAN_TIMEOUT_EN
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      vtx_q       <= vtx_d;
      dim_q       <= dim_d;
      res_cnt_q   <= res_cnt_d;
      found_q     <= found_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      pipe_v_q    <= pipe_v_d;
      pipe_d_q    <= pipe_d_d;
      pos_q       <= pos_d;
`ifdef SCAN_TIMEOUT_EN
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_distance_scan_ctrl.sv
// tb_distance_scan_ctrl
//   Coordinate memory and distance unit are behavioural stand-ins; expected
//   nearest vertex comes from a direct search over the stored coordinates.
module tb_distance_scan_ctrl;
  localparam int DIM     = 9;
  localparam int IDX_W   = 16;
  localparam int CADDR_W = 20;
  localparam int MEM_LAT = 2;
  localparam int RLAT    = 4;
  localparam int TMO     = 16;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               start_in;
  logic [IDX_W-1:0]   base_idx_in;
  logic [IDX_W-1:0]   count_in;
  logic               busy_out;
  logic [31:0]        best_dist_out;
  logic [IDX_W-1:0]   best_idx_out;
  logic               found_out;
  logic               done_out;
`ifdef SCAN_TIMEOUT_EN
  logic               timeout_out;
`endif

  distance_scan_ctrl_if #(.DIM(DIM), .CADDR_W(CADDR_W)) bus_if ();

  distance_scan_ctrl #(
    .DIM(DIM), .IDX_W(IDX_W), .CADDR_W(CADDR_W), .MEM_LAT(MEM_LAT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .base_idx_in   (base_idx_in),
    .count_in      (count_in),
    .busy_out      (busy_out),
    .best_dist_out (best_dist_out),
    .best_idx_out  (best_idx_out),
    .found_out     (found_out),
    .done_out      (done_out),
`ifdef SCAN_TIMEOUT_EN
    .timeout_out   (timeout_out),
`endif
    .bus           (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_vld_bad = 0;
  bit mute     = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- coordinate memory + distance unit stand-ins ----------
  logic [31:0] mem [int unsigned];
  int unsigned query [DIM];

  function automatic logic [31:0] coord(input int unsigned addr);
    if (mem.exists(addr)) return mem[addr];
    return (addr * 29 + 7) & 32'hFF;
  endfunction

  typedef struct { int due; logic [31:0] val; } res_t;
  res_t        resq [$];
  logic [31:0] vec [DIM];
  logic [CADDR_W:0] hist [MEM_LAT];

  initial for (int i = 0; i < MEM_LAT; i++) hist[i] = '0;

  always @(negedge clk_in) begin
    logic [31:0] s;
    int df;
    for (int i = MEM_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {bus_if.mem_rd_out, bus_if.mem_addr_out};
    if (bus_if.dist_valid_out != '0) begin
      if (!$onehot(bus_if.dist_valid_out)) n_vld_bad++;
      for (int d = 0; d < DIM; d++) begin
        if (bus_if.dist_valid_out[d]) begin
          vec[d] = bus_if.dist_vertex_pos_out[d];
          if (d == DIM - 1) begin
            s = 0;
            for (int j = 0; j < DIM; j++) begin
              df = int'(vec[j]) - int'(query[j]);
              s  = s + 32'(df * df);
            end
            if (!mute) resq.push_back('{cyc + RLAT, s});
          end
        end
      end
    end
  end

  always @(posedge clk_in) begin
    cyc = cyc + 1;
    #1;
    bus_if.mem_data_in = hist[MEM_LAT-1][CADDR_W] ?
                         coord(int'(hist[MEM_LAT-1][CADDR_W-1:0])) : 32'hDEAD_BEEF;
    if (resq.size() > 0 && resq[0].due == cyc) begin
      bus_if.dist_result_valid_in = 1'b1;
      bus_if.dist_result_in       = resq[0].val;
      void'(resq.pop_front());
    end else begin
      bus_if.dist_result_valid_in = 1'b0;
      bus_if.dist_result_in       = $urandom;
    end
  end

  // ---------------- reference: direct nearest-vertex search -------------
  function automatic logic [31:0] vdist(input int vi);
    logic [31:0] s = 0;
    int df;
    for (int d = 0; d < DIM; d++) begin
      df = int'(coord((vi * DIM + d) % (1 << CADDR_W))) - int'(query[d]);
      s  = s + 32'(df * df);
    end
    return s;
  endfunction

  task automatic run_scan(input string tag, input int base, input int cnt);
    logic [31:0] e_best = 32'hFFFF_FFFF;
    int e_idx = 0, e_done, t0, k;
    bit e_found = 1'b0;
    int done_cyc = -1, first_rd = -1, last_rd = -1, n_rd = 0;
    int first_vld = -1, n_vld = 0, n_busy = 0;
    logic busy0 = 1'b0;
    for (int v = 0; v < cnt; v++) begin
      e_found = 1'b1;
      if (vdist(base + v) < e_best) begin
        e_best = vdist(base + v);
        e_idx  = base + v;
      end
    end
    e_done = (cnt == 0) ? 1 : cnt * DIM + MEM_LAT + RLAT + 1;

    @(posedge clk_in); #1;
    base_idx_in = IDX_W'(base);
    count_in    = IDX_W'(cnt);
    start_in    = 1'b1;
    t0          = cyc;
    for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
      @(negedge clk_in);
      k = cyc - t0;
      if (k == 0) busy0 = busy_out;
      if (busy_out) n_busy++;
      if (bus_if.mem_rd_out) begin
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        n_rd++;
      end
      if (bus_if.dist_valid_out != '0) begin
        if (first_vld < 0) first_vld = k;
        n_vld++;
      end
      if (done_out) done_cyc = k;
      if (k == 0) begin @(posedge clk_in); #1 start_in = 1'b0; end
    end
    check_val({tag, "_done_cycle"}, 64'(done_cyc), 64'(e_done));
    check_val({tag, "_busy_c0"}, 64'(busy0), 0);
    check_val({tag, "_busy_cycles"}, 64'(n_busy), 64'(e_done));
    check_val({tag, "_rd_count"}, 64'(n_rd), 64'(cnt * DIM));
    check_val({tag, "_vld_count"}, 64'(n_vld), 64'(cnt * DIM));
    if (cnt > 0) begin
      check_val({tag, "_first_rd"}, 64'(first_rd), 1);
      check_val({tag, "_last_rd"}, 64'(last_rd), 64'(cnt * DIM));
      check_val({tag, "_first_vld"}, 64'(first_vld), 64'(1 + MEM_LAT));
      check_val({tag, "_best_idx"}, 64'(best_idx_out), 64'(IDX_W'(e_idx)));
    end
    @(negedge clk_in);
    check_val({tag, "_done_pulse"}, 64'(done_out), 0);
    check_val({tag, "_busy_after"}, 64'(busy_out), 0);
    check_val({tag, "_best_dist"}, 64'(best_dist_out), 64'(e_best));
    check_val({tag, "_found"}, 64'(found_out), 64'(e_found));
    repeat (3) @(negedge clk_in);
    check_val({tag, "_best_hold"}, 64'(best_dist_out), 64'(e_best));
  endtask

  function automatic void set_vertex(input int vi, input int unsigned c [DIM]);
    for (int d = 0; d < DIM; d++) mem[int'(vi * DIM + d)] = c[d];
  endfunction

  int unsigned spec_v [DIM] = '{89, 123, 231, 82, 7, 12, 20, 39, 19};
  int unsigned spec_q [DIM] = '{23, 67, 2, 99, 17, 103, 1, 53, 18};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tv [DIM];
    int n_act;
    rst_in = 1'b1; start_in = 1'b0; base_idx_in = '0; count_in = '0;
    query = spec_q;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_val("rst_busy", 64'(busy_out), 0);
    check_val("rst_mem_rd", 64'(bus_if.mem_rd_out), 0);
    check_val("rst_mem_addr", 64'(bus_if.mem_addr_out), 0);
    check_val("rst_dist_valid", 64'(bus_if.dist_valid_out), 0);
    check_val("rst_pos_nonzero", 64'(|bus_if.dist_vertex_pos_out), 0);
    check_val("rst_best_dist", 64'(best_dist_out), 64'h FFFF_FFFF);
    check_val("rst_best_idx", 64'(best_idx_out), 0);
    check_val("rst_found", 64'(found_out), 0);
    check_val("rst_done", 64'(done_out), 0);

    // single vertex, known answer
    set_vertex(5, spec_v);
    run_scan("one", 5, 1);
    check_val("one_const_dist", 64'(best_dist_out), 64'd69161);
    check_val("one_const_idx", 64'(best_idx_out), 64'd5);

    // middle vertex equals the query
    for (int d = 0; d < DIM; d++) tv[d] = $urandom_range(0, 255);
    set_vertex(100, tv);
    set_vertex(101, spec_q);
    for (int d = 0; d < DIM; d++) tv[d] = $urandom_range(0, 255);
    set_vertex(102, tv);
    run_scan("exact", 100, 3);
    check_val("exact_const_dist", 64'(best_dist_out), 0);
    check_val("exact_const_idx", 64'(best_idx_out), 64'd101);

    // tie at distance 500: lower index wins
    tv = spec_q; tv[0] = tv[0] + 10; tv[1] = tv[1] + 20; set_vertex(40, tv);
    tv = spec_q; tv[0] = tv[0] + 30;                      set_vertex(41, tv);
    tv = spec_q; tv[0] = tv[0] + 20; tv[1] = tv[1] + 10; set_vertex(42, tv);
    run_scan("tie", 40, 3);
    check_val("tie_const_dist", 64'(best_dist_out), 64'd500);
    check_val("tie_const_idx", 64'(best_idx_out), 64'd40);

    run_scan("zero", 7, 0);

    // reset in the middle of ISSUE with a result still in flight
    for (int v = 200; v < 204; v++) begin
      for (int d = 0; d < DIM; d++) tv[d] = $urandom_range(0, 255);
      set_vertex(v, tv);
    end
    @(posedge clk_in); #1;
    base_idx_in = 16'd200; count_in = 16'd4; start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    repeat (20) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_val("mrst_busy", 64'(busy_out), 0);
    check_val("mrst_mem_rd", 64'(bus_if.mem_rd_out), 0);
    check_val("mrst_pos_nonzero", 64'(|bus_if.dist_vertex_pos_out), 0);
    check_val("mrst_found", 64'(found_out), 0);
    n_act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (done_out || found_out || busy_out || bus_if.mem_rd_out ||
          bus_if.dist_valid_out != '0) n_act++;
    end
    check_val("mrst_quiet_cycles", 64'(n_act), 0);
    check_val("mrst_best_dist", 64'(best_dist_out), 64'hFFFF_FFFF);
    check_val("mrst_best_idx", 64'(best_idx_out), 0);
    run_scan("post_rst", 5, 1);
    check_val("post_rst_const", 64'(best_dist_out), 64'd69161);

    // randomized scans
    for (int t = 0; t < 25; t++) begin
      int b, c;
      b = $urandom_range(0, 600);
      c = $urandom_range(0, 6);
      for (int d = 0; d < DIM; d++) query[d] = $urandom_range(0, 255);
      for (int v = b; v < b + c; v++) begin
        for (int d = 0; d < DIM; d++) tv[d] = $urandom_range(0, 255);
        set_vertex(v, tv);
      end
      run_scan($sformatf("rnd%0d", t), b, c);
    end

`ifdef SCAN_TIMEOUT_EN
    begin
      int dc = -1, t0, tmo_seen = 0;
      query = spec_q;
      mute = 1'b1;
      @(posedge clk_in); #1;
      base_idx_in = 16'd5; count_in = 16'd1; start_in = 1'b1; t0 = cyc;
      @(posedge clk_in); #1 start_in = 1'b0;
      for (int i = 0; i < 200 && dc < 0; i++) begin
        @(negedge clk_in);
        if (done_out) begin dc = cyc - t0; tmo_seen = int'(timeout_out); end
      end
      // DRAIN starts at cycle DIM+1 for one vertex
      check_val("tmo_done_cycle", 64'(dc), 64'(DIM + 1 + TMO));
      check_val("tmo_flag", 64'(tmo_seen), 1);
      @(negedge clk_in);
      check_val("tmo_flag_clear", 64'(timeout_out), 0);
      mute = 1'b0;
    end
`endif

    check_val("onehot_violations", 64'(n_vld_bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
